sdma_chan_sched: RTL

- Shares one QL SDMA channel between NUM_REQ FPGA-side data sources, e.g. the decimation-filter FIFO and a raw I2S capture FIFO.
- Issues SDMA_Req/SDMA_Sreq for one granted source at a time and tracks the Active/Done handshake.
- Returns a one-hot grant that steers read data, plus per-source completion pulses and a combined DMA interrupt.
- Sits between the FPGA IP FIFOs and the SDMA port of the cell macro.

---
 rtl/sdma_chan_sched_pkg.sv | 22 ++
 rtl/sdma_chan_sched_if.sv | 23 ++
 rtl/sdma_chan_sched_rr_pick.sv | 39 +++
 rtl/sdma_chan_sched.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sdma_chan_sched_pkg.sv
// rtl/sdma_chan_sched_pkg.sv - shared types and limits for the SDMA channel scheduler
package sdma_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } sched_state_t;

  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int MIN_REQ         = 2;
  localparam int MAX_REQ         = 4;

  function automatic bit num_req_ok(input int n);
    return (n >= MIN_REQ) && (n <= MAX_REQ);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sdma_chan_sched_if.sv
// rtl/sdma_chan_sched_if.sv - SDMA request/acknowledge port of the cell macro
interface sdma_chan_sched_if;

  logic SDMA_Req_o;
  logic SDMA_Sreq_o;
  logic SDMA_Active_i;
  logic SDMA_Done_i;

  modport master (
    output SDMA_Req_o,
    output SDMA_Sreq_o,
    input  SDMA_Active_i,
    input  SDMA_Done_i
  );

  modport slave (
    input  SDMA_Req_o,
    input  SDMA_Sreq_o,
    output SDMA_Active_i,
    output SDMA_Done_i
  );

endinterface

// File: rtl/sdma_chan_sched_rr_pick.sv
// rtl/sdma_chan_sched_rr_pick.sv - rotating-priority one-hot selector
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] pos;
  logic          hit;

  // Scan from the pointer upward, wrapping, and keep the first eligible source.
  always_comb begin
    onehot = '0;
    idx    = '0;
    hit    = 1'b0;
    pos    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(NUM_REQ)) begin
        pos = pos - PW'(NUM_REQ);
      end
      if (!hit && eligible[pos[IDX_W-1:0]]) begin
        hit                     = 1'b1;
        onehot[pos[IDX_W-1:0]]  = 1'b1;
        idx                     = pos[IDX_W-1:0];
      end
    end
  end

  assign valid = hit;

endmodule

// File: rtl/sdma_chan_sched.sv
// rtl/sdma_chan_sched.sv - shares one SDMA channel between NUM_REQ FIFO sources
module sdma_chan_sched
  import sdma_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = 16
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST_N,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   single_i,
  input  logic [NUM_REQ-1:0]   en_i,
  sdma_chan_sched_if.master    sdma,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 dma_intr_o,
  output logic                 timeout_o,
  output logic                 err_sticky_o,
  input  logic                 err_clr_i,
  output logic [CNT_W-1:0]     xfer_cnt_o
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
    $error("sdma_chan_sched: NUM_REQ must be within 2..4");
  end

  sched_state_t        state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    g_q, g_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, next_ptr;
  logic                req_q, req_d, sreq_q, sreq_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                complete;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible (req_i & en_i),
    .ptr      (ptr_q),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  assign next_ptr = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    req_d     = req_q;
    sreq_d    = sreq_q;
    done_d    = '0;
    timeout_d = 1'b0;
    err_d     = err_q & ~err_clr_i;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    complete  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = REQ;
          grant_d = pick_onehot;
          g_d     = pick_idx;
          req_d   = ~single_i[pick_idx];
          sreq_d  = single_i[pick_idx];
          tcnt_d  = '0;
        end
      end
      REQ: begin
        if (sdma.SDMA_Active_i) begin
          req_d  = 1'b0;
          sreq_d = 1'b0;
          tcnt_d = '0;
          if (sdma.SDMA_Done_i) complete = 1'b1;
          else                  state_d  = XFER;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          // Give up on this owner; a timeout set beats a same-cycle clear.
          state_d   = IDLE;
          req_d     = 1'b0;
          sreq_d    = 1'b0;
          grant_d   = '0;
          timeout_d = 1'b1;
          err_d     = 1'b1;
          ptr_d     = next_ptr;
          tcnt_d    = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      XFER: begin
        if (sdma.SDMA_Done_i) complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      state_d = IDLE;
      done_d  = grant_q;
      cnt_d   = cnt_q + CNT_W'(1);
      grant_d = '0;
      ptr_d   = next_ptr;
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      g_q       <= '0;
      ptr_q     <= '0;
      req_q     <= 1'b0;
      sreq_q    <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      req_q     <= req_d;
      sreq_q    <= sreq_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign sdma.SDMA_Req_o  = req_q;
  assign sdma.SDMA_Sreq_o = sreq_q;
  assign grant_o          = grant_q;
  assign done_o           = done_q;
  assign dma_intr_o       = |done_q;
  assign timeout_o        = timeout_q;
  assign err_sticky_o     = err_q;
  assign xfer_cnt_o       = cnt_q;

endmodule
